// File: rtl/param_counter.sv
// Parametrised up/down event counter with wrap/one-shot modes, load/clear, and a run-state FSM.
// Latency: counter and flags update on the edge that samples the step. No backpressure; active is a level enable.
// Optional prescaler gating of count steps when CNT_PRESCALE_EN is defined.
module param_counter #(
    parameter int WIDTH    = 8,
    parameter int TOP      = 2**WIDTH-1,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             active,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear,
    output logic [WIDTH-1:0] counter,
    output logic             overflow,
    output logic             underflow,
    output logic             done,
    output logic             busy
);

    localparam logic [WIDTH-1:0] TOP_V = WIDTH'(TOP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             ovf_nxt;
    logic             unf_nxt;
    logic             pre_tc;
    logic             step;

`ifdef CNT_PRESCALE_EN
    localparam int            PW       = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_cnt;

    assign pre_tc = (pre_cnt == PRE_LAST);

    // Phase is preserved across inactive cycles so a paused run resumes mid-period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (clear || load) begin
            pre_cnt <= '0;
        end else if (active && (state != DONE)) begin
            pre_cnt <= pre_tc ? '0 : pre_cnt + 1'b1;
        end
    end
`else
    assign pre_tc = 1'b1;
`endif

    assign step = active && (state != DONE) && pre_tc;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = counter;
        ovf_nxt   = 1'b0;
        unf_nxt   = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (load) begin
            state_nxt = IDLE;
            cnt_nxt   = (load_val > TOP_V) ? TOP_V : load_val;
        end else begin
            case (state)
                IDLE:    if (active)  state_nxt = RUN;
                RUN:     if (!active) state_nxt = IDLE;
                default: state_nxt = state;
            endcase
            // A one-shot boundary step overrides the IDLE->RUN move above.
            if (step) begin
                if (dir) begin
                    if (counter != TOP_V) begin
                        cnt_nxt = counter + 1'b1;
                    end else begin
                        ovf_nxt = 1'b1;
                        if (mode) state_nxt = DONE;
                        else      cnt_nxt   = '0;
                    end
                end else begin
                    if (counter != '0) begin
                        cnt_nxt = counter - 1'b1;
                    end else begin
                        unf_nxt = 1'b1;
                        if (mode) state_nxt = DONE;
                        else      cnt_nxt   = TOP_V;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            counter   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            counter   <= cnt_nxt;
            overflow  <= ovf_nxt;
            underflow <= unf_nxt;
            done      <= (state_nxt == DONE);
            busy      <= (state_nxt == RUN);
        end
    end

endmodule

// File: tb/tb_param_counter.sv
// Directed bench for param_counter: a full-range instance (TOP=255) and a small-range instance (TOP=9) share stimulus.
module tb_param_counter;

    logic       clk;
    logic       rst;
    logic       active;
    logic       dir;
    logic       mode;
    logic       load;
    logic [7:0] load_val;
    logic       clear;

    logic [7:0] cnt_f, cnt_s;
    logic       ovf_f, unf_f, done_f, busy_f;
    logic       ovf_s, unf_s, done_s, busy_s;

    int n_checks = 0;
    int n_pass   = 0;

    param_counter #(.WIDTH(8)) u_full (
        .clk(clk), .rst(rst), .active(active), .dir(dir), .mode(mode),
        .load(load), .load_val(load_val), .clear(clear),
        .counter(cnt_f), .overflow(ovf_f), .underflow(unf_f), .done(done_f), .busy(busy_f)
    );

    param_counter #(.WIDTH(8), .TOP(9)) u_small (
        .clk(clk), .rst(rst), .active(active), .dir(dir), .mode(mode),
        .load(load), .load_val(load_val), .clear(clear),
        .counter(cnt_s), .overflow(ovf_s), .underflow(unf_s), .done(done_s), .busy(busy_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; active = 1'b0; dir = 1'b1; mode = 1'b0;
        load = 1'b0; load_val = '0; clear = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic load_small(input logic [7:0] v);
        active = 1'b0; load = 1'b1; load_val = v;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({cnt_f, ovf_f, unf_f, done_f, busy_f} !== 12'h000) $display("FAIL reset_full got %h want 000", {cnt_f, ovf_f, unf_f, done_f, busy_f});
        else n_pass++;
        n_checks++;
        if ({cnt_s, ovf_s, unf_s, done_s, busy_s} !== 12'h000) $display("FAIL reset_small got %h want 000", {cnt_s, ovf_s, unf_s, done_s, busy_s});
        else n_pass++;
    endtask

    task automatic test_wrap_up();
        do_reset();
        active = 1'b1; dir = 1'b1; mode = 1'b0;
        for (int i = 1; i <= 257; i++) begin
            tick();
            n_checks++;
            if (cnt_f !== 8'(i % 256)) $display("FAIL wrap_cnt cyc %0d got %0d want %0d", i, cnt_f, i % 256);
            else n_pass++;
            n_checks++;
            if (ovf_f !== (i == 256)) $display("FAIL wrap_ovf cyc %0d got %b want %b", i, ovf_f, (i == 256));
            else n_pass++;
            n_checks++;
            if (busy_f !== 1'b1) $display("FAIL wrap_busy cyc %0d got %b want 1", i, busy_f);
            else n_pass++;
        end
    endtask

    task automatic test_oneshot_up();
        do_reset();
        active = 1'b1; dir = 1'b1; mode = 1'b1;
        repeat (9) tick();
        n_checks++;
        if ({cnt_s, ovf_s, done_s, busy_s} !== {8'd9, 3'b001}) $display("FAIL os_at_top got %0d/%b%b%b want 9/001", cnt_s, ovf_s, done_s, busy_s);
        else n_pass++;
        tick();
        n_checks++;
        if ({cnt_s, ovf_s, done_s, busy_s} !== {8'd9, 3'b110}) $display("FAIL os_boundary got %0d/%b%b%b want 9/110", cnt_s, ovf_s, done_s, busy_s);
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if ({cnt_s, ovf_s, done_s, busy_s} !== {8'd9, 3'b010}) $display("FAIL os_hold cyc %0d got %0d/%b%b%b want 9/010", i, cnt_s, ovf_s, done_s, busy_s);
            else n_pass++;
        end
        load = 1'b1; load_val = 8'd3;
        tick();
        load = 1'b0;
        n_checks++;
        if ({cnt_s, ovf_s, done_s, busy_s} !== {8'd3, 3'b000}) $display("FAIL os_reload got %0d/%b%b%b want 3/000", cnt_s, ovf_s, done_s, busy_s);
        else n_pass++;
        tick();
        n_checks++;
        if ({cnt_s, busy_s} !== {8'd4, 1'b1}) $display("FAIL os_restart got %0d/%b want 4/1", cnt_s, busy_s);
        else n_pass++;
    endtask

    task automatic test_down();
        do_reset();
        load_small(8'd1);
        dir = 1'b0; mode = 1'b0; active = 1'b1;
        tick();
        n_checks++;
        if ({cnt_s, unf_s} !== {8'd0, 1'b0}) $display("FAIL down_to0 got %0d/%b want 0/0", cnt_s, unf_s);
        else n_pass++;
        tick();
        n_checks++;
        if ({cnt_s, unf_s, ovf_s} !== {8'd9, 2'b10}) $display("FAIL down_wrap got %0d/%b%b want 9/10", cnt_s, unf_s, ovf_s);
        else n_pass++;
        tick();
        n_checks++;
        if ({cnt_s, unf_s} !== {8'd8, 1'b0}) $display("FAIL down_after got %0d/%b want 8/0", cnt_s, unf_s);
        else n_pass++;
        load_small(8'd200);
        n_checks++;
        if (cnt_s !== 8'd9) $display("FAIL load_clamp got %0d want 9", cnt_s);
        else n_pass++;
        n_checks++;
        if (cnt_f !== 8'd200) $display("FAIL load_noclamp got %0d want 200", cnt_f);
        else n_pass++;
        load_small(8'd0);
        mode = 1'b1; active = 1'b1;
        tick();
        n_checks++;
        if ({cnt_s, unf_s, done_s, busy_s} !== {8'd0, 3'b110}) $display("FAIL down_oneshot got %0d/%b%b%b want 0/110", cnt_s, unf_s, done_s, busy_s);
        else n_pass++;
    endtask

    task automatic test_active_toggle();
        logic [7:0] act_v  = 8'b1011_0101; // applied LSB first
        logic [7:0] busy_v = 8'b1011_0101;
        logic [7:0] exp_c [8] = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd4, 8'd4, 8'd5};
        do_reset();
        dir = 1'b1; mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            active = act_v[i];
            tick();
            n_checks++;
            if ({cnt_f, busy_f} !== {exp_c[i], busy_v[i]}) $display("FAIL toggle cyc %0d got %0d/%b want %0d/%b", i, cnt_f, busy_f, exp_c[i], busy_v[i]);
            else n_pass++;
        end
    endtask

    task automatic test_dir_change();
        do_reset();
        load_small(8'd5);
        dir = 1'b1; mode = 1'b0; active = 1'b1;
        tick();
        tick();
        dir = 1'b0;
        tick();
        n_checks++;
        if (cnt_s !== 8'd6) $display("FAIL dir_change got %0d want 6", cnt_s);
        else n_pass++;
    endtask

    task automatic test_clear_load_prio();
        do_reset();
        load_small(8'd9);
        dir = 1'b1; mode = 1'b0; active = 1'b1; clear = 1'b1;
        tick();
        clear = 1'b0;
        n_checks++;
        if ({cnt_s, ovf_s, busy_s} !== {8'd0, 2'b00}) $display("FAIL clear_at_top got %0d/%b%b want 0/00", cnt_s, ovf_s, busy_s);
        else n_pass++;
        load_small(8'd9);
        active = 1'b1; load = 1'b1; load_val = 8'd9;
        tick();
        load = 1'b0;
        n_checks++;
        if ({cnt_s, ovf_s} !== {8'd9, 1'b0}) $display("FAIL load_at_top got %0d/%b want 9/0", cnt_s, ovf_s);
        else n_pass++;
        load_small(8'd0);
        active = 1'b1;
        tick();
        tick();
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if ({cnt_s, busy_s} !== {8'd0, 1'b0}) $display("FAIL async_rst got %0d/%b want 0/0", cnt_s, busy_s);
        else n_pass++;
        rst = 1'b0;
        active = 1'b0;
    endtask

`ifdef CNT_PRESCALE_EN
    task automatic test_prescale();
        do_reset();
        dir = 1'b1; mode = 1'b0; active = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            tick();
            n_checks++;
            if (cnt_f !== 8'(i / 4)) $display("FAIL pre_run cyc %0d got %0d want %0d", i, cnt_f, i / 4);
            else n_pass++;
        end
        active = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({cnt_f, busy_f} !== {8'd4, 1'b0}) $display("FAIL pre_pause got %0d/%b want 4/0", cnt_f, busy_f);
        else n_pass++;
        active = 1'b1;
        tick();
        n_checks++;
        if (cnt_f !== 8'd4) $display("FAIL pre_resume1 got %0d want 4", cnt_f);
        else n_pass++;
        tick();
        n_checks++;
        if (cnt_f !== 8'd5) $display("FAIL pre_resume2 got %0d want 5", cnt_f);
        else n_pass++;
    endtask
`endif

    initial begin
        rst = 1'b1; active = 1'b0; dir = 1'b1; mode = 1'b0;
        load = 1'b0; load_val = '0; clear = 1'b0;
        test_reset();
`ifdef CNT_PRESCALE_EN
        test_prescale();
`else
        test_wrap_up();
        test_oneshot_up();
        test_down();
        test_active_toggle();
        test_dir_change();
        test_clear_load_prio();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
